jk_updown_counter_n: RTL

- Parametrised modulo-N up/down counter. Successor to the fixed 2-bit JK ripple-free up counter.
- Every state bit is a JK cell wired as a toggle (J=K=toggle_i). Per-bit toggle enables come from the direction, enable and terminal-count logic.
- Adds direction control, count enable, synchronous parallel load, configurable modulus, saturate mode and terminal-count/wrap flags.
- Used as a generic event/divider counter in lab datapaths.

---
 rtl/jk_updown_counter_n.sv | 85 ++++++++
 1 files changed

// File: rtl/jk_updown_counter_n.sv
// Modulo-N up/down counter built from JK toggle cells, with load, saturate,
// combinational terminal-count and registered wrap pulse.
module jk_updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam int unsigned     W     = WIDTH;
    localparam logic [W-1:0]    MAX_Q = W'(MODULUS - 1);
    localparam bit              SAT   = (SATURATE != 0);

    // Reject illegal parameterisations at elaboration.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_updown_counter_n: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("jk_updown_counter_n: MODULUS must be 2..2**WIDTH");
    end

    logic [W-1:0] next_q;
    logic         next_wrap;
    logic [W-1:0] toggle;
    logic [W-1:0] term_val;

    assign term_val = up_dn ? MAX_Q : '0;
    assign tc       = en & ~load & (q == term_val);

    // Target value for the next edge; the terminal cases are explicit so a
    // full-range modulus never depends on binary overflow.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (q == MAX_Q) begin
                    if (!SAT) begin
                        next_q    = '0;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_q = q + W'(1);
                end
            end else begin
                if (q == '0) begin
                    if (!SAT) begin
                        next_q    = MAX_Q;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_q = q - W'(1);
                end
            end
        end
    end

    // Each bit toggles exactly where it must change to reach the target.
    assign toggle = q ^ next_q;

    // JK cells with J = K = toggle: q+ = J&~q | ~K&q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q[i] <= (toggle[i] & ~q[i]) | (~toggle[i] & q[i]);
            end
            wrap <= next_wrap;
        end
    end

endmodule
